alu_execute: RTL and testbench
==============================

ALU_EXECUTE -- requirements
Module: alu_execute

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL have: rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have: in_valid  in  1  operation presented this cycle.
REQ-004 SHALL have: in_ready  out  1  block can accept an operation.
REQ-005 SHALL have: alu_select  in  6  operation code from the ALU decode stage.
REQ-006 SHALL have: op_a, op_b, imm, pc  in  32 each  rs1 value, rs2 value, sign-extended immediate (LUI/AUIPC pre-shifted), instruction PC.
REQ-007 SHALL have: out_valid  out  1  one-cycle pulse, result fields valid.
REQ-008 SHALL have: result  out  32  ALU result, link value or effective address.
REQ-009 SHALL have: branch_taken  out  1  control transfer taken; target  out  32  transfer target.
REQ-010 SHALL have: illegal  out  1  alu_select code not executable.

Function
REQ-011 SHALL accept an operation on a rising edge where in_valid and in_ready are both 1.
REQ-012 SHALL, for every code except 001010 (mul), assert out_valid exactly 1 cycle after acceptance with registered result.
REQ-013 SHALL hold in_ready=1 in IDLE, allowing back-to-back single-cycle operations.
REQ-014 SHALL compute 000000 add a+b; 000001 sub a-b; 000010 and; 000011 or; 000100 xor; 000101 slt signed; 000110 sltu; 000111 sra; 001000 srl; 001001 sll (shift amount op_b[4:0]).
REQ-015 SHALL compute immediate forms 001011..010100 identically, with imm replacing op_b (001100 = a-imm; shift amount imm[4:0]); set-less-than results are 32'd0/32'd1.
REQ-016 SHALL compute 010101 lui result=imm; 010110 auipc result=pc+imm; 010111 lw and 011000 sw result=op_a+imm.
REQ-017 SHALL for 011001 jr: result=pc+4, target=op_a&~1; 011010 jalr: result=pc+4, target=(op_a+imm)&~1; 011011 jal: result=pc+4, target=pc+imm; branch_taken=1 for all three.
REQ-018 SHALL for 011100..100001 (beq, bne, blt, bge, bltu, bgeu) compare op_a/op_b, target=pc+imm, result=0, branch_taken=compare outcome.
REQ-019 SHALL for non-transfer ops drive branch_taken=0, target=0.
REQ-020 SHALL for codes 100010..111111 assert illegal=1 with out_valid, result=0, branch_taken=0.
REQ-021 SHALL hold result, target, branch_taken, illegal stable until the next out_valid; all 32-bit arithmetic wraps modulo 2^32.
REQ-022 SHALL implement mul with FSM IDLE -> MUL -> DONE -> IDLE: accept in IDLE, MUL runs 32 shift-add iterations (one per cycle) on op_a*op_b, DONE asserts out_valid with low 32 bits of product.
REQ-023 SHALL give mul latency of exactly 33 cycles acceptance-to-out_valid; in_ready=0 in MUL and DONE, in_valid ignored there.
REQ-024 SHALL latch operands at acceptance; input changes during MUL do not affect the product.

Reset
REQ-025 SHALL on rst_n=0, immediately and regardless of clk: state=IDLE, in_ready=1, out_valid=0, result=0, target=0, branch_taken=0, illegal=0, iteration counter=0.
REQ-026 SHALL abandon an in-flight mul on reset with no out_valid afterwards.
REQ-027 SHALL accept a new operation on the first rising edge after rst_n deasserts.

Configuration
REQ-028 SHALL with macro ALU_MUL_EN defined include the mul FSM per REQ-022..024.
REQ-029 SHALL with ALU_MUL_EN undefined treat 001010 as illegal per REQ-020 (1-cycle latency), in_ready constant 1 outside reset, no multiplier state present.

Verification
REQ-030 SHALL cover back-to-back: add 5+7 then sub 5-7 on consecutive cycles -> out_valid two consecutive cycles, result 12 then 0xFFFFFFFE.
REQ-031 SHALL cover sra op_a=0x80000000, op_b=4 -> 0xF8000000; srl same -> 0x08000000; slt -1<1 -> 1; sltu 0xFFFFFFFF<1 -> 0.
REQ-032 SHALL cover bne a=3,b=4,pc=0x100,imm=0x20 -> branch_taken=1, target=0x120; beq same -> branch_taken=0; jalr a=0x201,imm=4,pc=0x40 -> result 0x44, target 0x204.
REQ-033 SHALL cover mul (ALU_MUL_EN) 0xFFFFFFFF*3 -> out_valid 33 cycles later, result 0xFFFFFFFD, in_ready=0 throughout, second op held off then accepted.
REQ-034 SHALL cover rst_n pulsed low 10 cycles into mul -> outputs zero immediately, no out_valid afterward, next add accepted.
REQ-035 SHALL cover alu_select 6'b111111 -> illegal=1, result 0; ALU_MUL_EN undefined with 001010 -> illegal=1 after 1 cycle.

Source files
------------

// File: rtl/alu_execute.sv
// -----------------------------------------------------------------------------
// alu_execute
//   Execute stage ALU. It takes one decoded operation per cycle and returns a
//   registered result one cycle after acceptance. Integer add/sub/logic/
//   compare/shift, LUI/AUIPC, load/store address generation, jumps and
//   conditional branches are all single-cycle.
//
//   Optional feature, macro ALU_MUL_EN:
//     defined   -> opcode 001010 (mul) runs on a 32-iteration shift-add
//                  multiplier (IDLE -> MUL -> DONE -> IDLE), 33-cycle latency.
//     undefined -> 001010 is reported as illegal like any other unused code.
//
//   Handshake: an operation is accepted on a rising clk edge where in_valid
//   and in_ready are both 1. out_valid is a one-cycle pulse, and
//   result/target/branch_taken/illegal hold their values until the next pulse.
//
// Ports
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   in_valid / in_ready input handshake
//   alu_select [5:0]    operation code
//   op_a, op_b          rs1 / rs2 values
//   imm                 sign-extended immediate (LUI/AUIPC already shifted)
//   pc                  instruction address
//   out_valid           result pulse
//   result              ALU result, link value or effective address
//   branch_taken        control transfer taken
//   target              transfer target (0 for non-transfer ops)
//   illegal             alu_select not executable
//   dbg_state [1:0]     FSM state (0 IDLE, 1 MUL, 2 DONE; always 0 without mul)
// -----------------------------------------------------------------------------
module alu_execute (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  alu_select,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [31:0] imm,
  input  logic [31:0] pc,
  output logic        out_valid,
  output logic [31:0] result,
  output logic        branch_taken,
  output logic [31:0] target,
  output logic        illegal,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [5:0] OP_MUL   = 6'd10;
  localparam logic [5:0] OP_IMM_0 = 6'd11;  // first immediate-form arith op
  localparam logic [5:0] OP_IMM_9 = 6'd20;  // last immediate-form arith op

  // ---------------------------------------------------------------------------
  // Single-cycle datapath (combinational)
  // ---------------------------------------------------------------------------
  logic        is_arith;
  logic [5:0]  arith_idx;
  logic [31:0] rhs;
  logic [4:0]  shamt;
  logic [31:0] res_c;
  logic [31:0] tgt_c;
  logic        br_c;
  logic        ill_c;

  always_comb begin
    is_arith  = (alu_select <= 6'd9);
    arith_idx = alu_select;
    rhs       = op_b;
    res_c     = 32'd0;
    tgt_c     = 32'd0;
    br_c      = 1'b0;
    ill_c     = 1'b0;

    // Immediate forms reuse the register-register encodings 0..9 with imm
    // standing in for op_b.
    if (alu_select >= OP_IMM_0 && alu_select <= OP_IMM_9) begin
      is_arith  = 1'b1;
      arith_idx = alu_select - OP_IMM_0;
      rhs       = imm;
    end
    shamt = rhs[4:0];

    if (is_arith) begin
      case (arith_idx)
        6'd0:    res_c = op_a + rhs;
        6'd1:    res_c = op_a - rhs;
        6'd2:    res_c = op_a & rhs;
        6'd3:    res_c = op_a | rhs;
        6'd4:    res_c = op_a ^ rhs;
        6'd5:    res_c = {31'd0, ($signed(op_a) < $signed(rhs))};
        6'd6:    res_c = {31'd0, (op_a < rhs)};
        6'd7:    res_c = $unsigned($signed(op_a) >>> shamt);
        6'd8:    res_c = op_a >> shamt;
        6'd9:    res_c = op_a << shamt;
        default: res_c = 32'd0;
      endcase
    end else begin
      case (alu_select)
        6'd21: res_c = imm;                       // lui
        6'd22: res_c = pc + imm;                  // auipc
        6'd23,
        6'd24: res_c = op_a + imm;                // lw / sw address
        6'd25: begin                              // jr
          res_c = pc + 32'd4;
          tgt_c = op_a & ~32'd1;
          br_c  = 1'b1;
        end
        6'd26: begin                              // jalr
          res_c = pc + 32'd4;
          tgt_c = (op_a + imm) & ~32'd1;
          br_c  = 1'b1;
        end
        6'd27: begin                              // jal
          res_c = pc + 32'd4;
          tgt_c = pc + imm;
          br_c  = 1'b1;
        end
        6'd28: begin tgt_c = pc + imm; br_c = (op_a == op_b);                   end
        6'd29: begin tgt_c = pc + imm; br_c = (op_a != op_b);                   end
        6'd30: begin tgt_c = pc + imm; br_c = ($signed(op_a) <  $signed(op_b)); end
        6'd31: begin tgt_c = pc + imm; br_c = ($signed(op_a) >= $signed(op_b)); end
        6'd32: begin tgt_c = pc + imm; br_c = (op_a <  op_b);                   end
        6'd33: begin tgt_c = pc + imm; br_c = (op_a >= op_b);                   end
        // 001010 lands here too; with the multiplier built it is steered to
        // the FSM before this decode is ever used.
        default: ill_c = 1'b1;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output registers (and multiplier when enabled)
  // ---------------------------------------------------------------------------
  logic        out_valid_q;
  logic [31:0] result_q;
  logic [31:0] target_q;
  logic        branch_q;
  logic        illegal_q;

`ifdef ALU_MUL_EN
  state_e      state_q;
  logic [31:0] mcand_q;   // multiplicand, shifted left each iteration
  logic [31:0] mplier_q;  // multiplier, shifted right each iteration
  logic [31:0] acc_q;     // running low 32 bits of the product
  logic [4:0]  iter_q;
  logic [31:0] acc_d;

  assign acc_d = acc_q + (mplier_q[0] ? mcand_q : 32'd0);

  // Operands are copied into mcand_q/mplier_q at acceptance, so op_a/op_b may
  // change freely while the multiply runs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= 32'd0;
      target_q    <= 32'd0;
      branch_q    <= 1'b0;
      illegal_q   <= 1'b0;
      mcand_q     <= 32'd0;
      mplier_q    <= 32'd0;
      acc_q       <= 32'd0;
      iter_q      <= 5'd0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            if (alu_select == OP_MUL) begin
              mcand_q  <= op_a;
              mplier_q <= op_b;
              acc_q    <= 32'd0;
              iter_q   <= 5'd0;
              state_q  <= ST_MUL;
            end else begin
              out_valid_q <= 1'b1;
              result_q    <= res_c;
              target_q    <= tgt_c;
              branch_q    <= br_c;
              illegal_q   <= ill_c;
            end
          end
        end
        ST_MUL: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          iter_q   <= iter_q + 5'd1;
          // Last of 32 iterations: publish the product as DONE is entered.
          if (iter_q == 5'd31) begin
            state_q     <= ST_DONE;
            out_valid_q <= 1'b1;
            result_q    <= acc_d;
            target_q    <= 32'd0;
            branch_q    <= 1'b0;
            illegal_q   <= 1'b0;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign dbg_state = state_q;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= 32'd0;
      target_q    <= 32'd0;
      branch_q    <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        result_q  <= res_c;
        target_q  <= tgt_c;
        branch_q  <= br_c;
        illegal_q <= ill_c;
      end
    end
  end

  assign in_ready  = 1'b1;
  assign dbg_state = ST_IDLE;
`endif

  assign out_valid    = out_valid_q;
  assign result       = result_q;
  assign target       = target_q;
  assign branch_taken = branch_q;
  assign illegal      = illegal_q;

endmodule

// File: tb/tb_alu_execute.sv
// -----------------------------------------------------------------------------
// tb_alu_execute
//   Self-checking bench for alu_execute. Expected results come from a
//   behavioural model of the operation table (alu_model) or from constants.
//   Multiplier scenarios are compiled only when ALU_MUL_EN is defined.
//   Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_alu_execute;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  alu_select = 6'd0;
  logic [31:0] op_a = 32'd0;
  logic [31:0] op_b = 32'd0;
  logic [31:0] imm = 32'd0;
  logic [31:0] pc = 32'd0;
  logic        out_valid;
  logic [31:0] result;
  logic        branch_taken;
  logic [31:0] target;
  logic        illegal;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  alu_execute dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .alu_select   (alu_select),
    .op_a         (op_a),
    .op_b         (op_b),
    .imm          (imm),
    .pc           (pc),
    .out_valid    (out_valid),
    .result       (result),
    .branch_taken (branch_taken),
    .target       (target),
    .illegal      (illegal),
    .dbg_state    (dbg_state)
  );

  int total = 0;
  int bad   = 0;

  // Expected entries are packed {illegal, branch_taken, target, result}.
  logic [65:0] exp_q[$];

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic [65:0] alu_model(input logic [5:0] sel,
                                            input logic [31:0] a, b, im, p);
    logic [31:0] r;
    logic [31:0] t;
    logic        br;
    logic        ill;
    r = 32'd0; t = 32'd0; br = 1'b0; ill = 1'b0;
    // Immediate arithmetic behaves like the register form with imm as rhs.
    if (sel >= 6'd11 && sel <= 6'd20)
      return alu_model(sel - 6'd11, a, im, im, p);
    case (sel)
      6'd0:  r = a + b;
      6'd1:  r = a - b;
      6'd2:  r = a & b;
      6'd3:  r = a | b;
      6'd4:  r = a ^ b;
      6'd5:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'd6:  r = (a < b) ? 32'd1 : 32'd0;
      6'd7:  r = $unsigned($signed(a) >>> b[4:0]);
      6'd8:  r = a >> b[4:0];
      6'd9:  r = a << b[4:0];
`ifdef ALU_MUL_EN
      6'd10: r = a * b;
`else
      6'd10: ill = 1'b1;
`endif
      6'd21: r = im;
      6'd22: r = p + im;
      6'd23, 6'd24: r = a + im;
      6'd25: begin r = p + 32'd4; t = a & ~32'd1;        br = 1'b1; end
      6'd26: begin r = p + 32'd4; t = (a + im) & ~32'd1; br = 1'b1; end
      6'd27: begin r = p + 32'd4; t = p + im;            br = 1'b1; end
      6'd28: begin t = p + im; br = (a == b); end
      6'd29: begin t = p + im; br = (a != b); end
      6'd30: begin t = p + im; br = ($signed(a) <  $signed(b)); end
      6'd31: begin t = p + im; br = ($signed(a) >= $signed(b)); end
      6'd32: begin t = p + im; br = (a <  b); end
      6'd33: begin t = p + im; br = (a >= b); end
      default: ill = 1'b1;
    endcase
    return {ill, br, t, r};
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 3));
      default: return $urandom();
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  task automatic drive_op(input logic [5:0] sel, input logic [31:0] a, b, im, p);
    alu_select = sel;
    op_a       = a;
    op_b       = b;
    imm        = im;
    pc         = p;
    in_valid   = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || result !== 32'd0 || target !== 32'd0 ||
        branch_taken !== 1'b0 || illegal !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_values: ov=%b res=%h tgt=%h br=%b ill=%b rdy=%b, want 0/0/0/0/0/1",
               out_valid, result, target, branch_taken, illegal, in_ready);
    end
    // Operation presented with the reset release must be taken on the next edge.
    rst_n = 1'b1;
    drive_op(6'd0, 32'd40, 32'd2, 32'd0, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || result !== 32'd42) begin
      bad++;
      $display("FAIL first_after_reset: ov=%b res=%h, want 1/0000002a", out_valid, result);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] want[2];
    want[0] = 32'd12;
    want[1] = 32'hFFFF_FFFE;
    @(negedge clk);
    drive_op(6'd0, 32'd5, 32'd7, 32'd0, 32'd0);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || result !== want[0]) begin
      bad++;
      $display("FAIL b2b_add: ov=%b res=%h, want 1/%h", out_valid, result, want[0]);
    end
    drive_op(6'd1, 32'd5, 32'd7, 32'd0, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || result !== want[1]) begin
      bad++;
      $display("FAIL b2b_sub: ov=%b res=%h, want 1/%h", out_valid, result, want[1]);
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || result !== want[1]) begin
      bad++;
      $display("FAIL b2b_pulse_end: ov=%b res=%h, want 0/%h", out_valid, result, want[1]);
    end
  endtask

  task automatic test_directed();
    logic [5:0]  sel[10];
    logic [31:0] a[10], b[10], im[10], p[10];
    logic [65:0] want[10];
    sel[0] = 6'd7;  a[0] = 32'h8000_0000; b[0] = 32'd4; im[0] = 0; p[0] = 0;
    want[0] = {1'b0, 1'b0, 32'd0, 32'hF800_0000};
    sel[1] = 6'd8;  a[1] = 32'h8000_0000; b[1] = 32'd4; im[1] = 0; p[1] = 0;
    want[1] = {1'b0, 1'b0, 32'd0, 32'h0800_0000};
    sel[2] = 6'd5;  a[2] = 32'hFFFF_FFFF; b[2] = 32'd1; im[2] = 0; p[2] = 0;
    want[2] = {1'b0, 1'b0, 32'd0, 32'd1};
    sel[3] = 6'd6;  a[3] = 32'hFFFF_FFFF; b[3] = 32'd1; im[3] = 0; p[3] = 0;
    want[3] = {1'b0, 1'b0, 32'd0, 32'd0};
    sel[4] = 6'd29; a[4] = 32'd3; b[4] = 32'd4; im[4] = 32'h20; p[4] = 32'h100;
    want[4] = {1'b0, 1'b1, 32'h120, 32'd0};
    sel[5] = 6'd28; a[5] = 32'd3; b[5] = 32'd4; im[5] = 32'h20; p[5] = 32'h100;
    want[5] = {1'b0, 1'b0, 32'h120, 32'd0};
    sel[6] = 6'd26; a[6] = 32'h201; b[6] = 32'd9; im[6] = 32'd4; p[6] = 32'h40;
    want[6] = {1'b0, 1'b1, 32'h204, 32'h44};
    sel[7] = 6'd63; a[7] = 32'd77; b[7] = 32'd5; im[7] = 32'd3; p[7] = 32'h10;
    want[7] = {1'b1, 1'b0, 32'd0, 32'd0};
    sel[8] = 6'd12; a[8] = 32'd10; b[8] = 32'd99; im[8] = 32'd3; p[8] = 0;
    want[8] = {1'b0, 1'b0, 32'd0, 32'd7};
    sel[9] = 6'd21; a[9] = 32'd1; b[9] = 32'd2; im[9] = 32'h1234_5000; p[9] = 0;
    want[9] = {1'b0, 1'b0, 32'd0, 32'h1234_5000};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive_op(sel[i], a[i], b[i], im[i], p[i]);
      @(negedge clk);
      in_valid = 1'b0;
      total++;
      if (out_valid !== 1'b1 || {illegal, branch_taken, target, result} !== want[i]) begin
        bad++;
        $display("FAIL directed_%0d sel=%0d: ov=%b ill=%b br=%b tgt=%h res=%h, want ill=%b br=%b tgt=%h res=%h",
                 i, sel[i], out_valid, illegal, branch_taken, target, result,
                 want[i][65], want[i][64], want[i][63:32], want[i][31:0]);
      end
    end
  endtask

  task automatic test_illegal();
    logic [5:0] codes[2];
    codes[0] = 6'b111111;
    codes[1] = 6'b100010;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive_op(codes[i], 32'hDEAD_BEEF, 32'h1234, 32'h55, 32'h400);
      @(negedge clk);
      in_valid = 1'b0;
      total++;
      if (out_valid !== 1'b1 || illegal !== 1'b1 || result !== 32'd0 ||
          branch_taken !== 1'b0 || target !== 32'd0) begin
        bad++;
        $display("FAIL illegal_%b: ov=%b ill=%b res=%h br=%b tgt=%h, want 1/1/0/0/0",
                 codes[i], out_valid, illegal, result, branch_taken, target);
      end
    end
`ifndef ALU_MUL_EN
    @(negedge clk);
    drive_op(6'b001010, 32'd6, 32'd7, 32'd0, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || illegal !== 1'b1 || result !== 32'd0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL mul_disabled: ov=%b ill=%b res=%h rdy=%b, want 1/1/0/1",
               out_valid, illegal, result, in_ready);
    end
`endif
  endtask

  task automatic test_random();
    logic [5:0]  sel;
    logic [31:0] a, b, im, p;
    logic [65:0] want;
    for (int i = 0; i < 150; i++) begin
      sel = 6'($urandom_range(0, 63));
`ifdef ALU_MUL_EN
      if (sel == 6'd10) sel = 6'd0;
`endif
      a  = pick_operand();
      b  = pick_operand();
      im = pick_operand();
      p  = $urandom() & ~32'd3;
      @(negedge clk);
      drive_op(sel, a, b, im, p);
      exp_q.push_back(alu_model(sel, a, b, im, p));
      @(negedge clk);
      in_valid = 1'b0;
      want = exp_q.pop_front();
      total++;
      if (out_valid !== 1'b1 || {illegal, branch_taken, target, result} !== want) begin
        bad++;
        $display("FAIL random_%0d sel=%0d a=%h b=%h imm=%h pc=%h: ov=%b ill=%b br=%b tgt=%h res=%h, want ill=%b br=%b tgt=%h res=%h",
                 i, sel, a, b, im, p, out_valid, illegal, branch_taken, target, result,
                 want[65], want[64], want[63:32], want[31:0]);
      end
      // Occasional idle cycle: the pulse must drop while the fields hold.
      if ($urandom_range(0, 2) == 0) begin
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || {illegal, branch_taken, target, result} !== want) begin
          bad++;
          $display("FAIL hold_%0d: ov=%b ill=%b br=%b tgt=%h res=%h, want pulse 0 and fields unchanged",
                   i, out_valid, illegal, branch_taken, target, result);
        end
      end
    end
  endtask

`ifdef ALU_MUL_EN
  task automatic test_mul();
    logic [31:0] held;
    int          lat;
    int          wait2;
    logic        ready_err;
    logic        hold_err;
    held      = result;
    lat       = 0;
    wait2     = 0;
    ready_err = 1'b0;
    hold_err  = 1'b0;
    @(negedge clk);
    drive_op(6'd10, 32'hFFFF_FFFF, 32'd3, 32'd0, 32'd0);
    for (int i = 1; i <= 60 && lat == 0; i++) begin
      @(negedge clk);
      // A second op (add 100+23) waits at the input with different operands.
      if (i == 1) drive_op(6'd0, 32'd100, 32'd23, 32'd0, 32'd0);
      if (in_ready !== 1'b0) ready_err = 1'b1;
      if (out_valid === 1'b1) lat = i;
      else if (result !== held) hold_err = 1'b1;
    end
    total++;
    if (lat != 33 || result !== 32'hFFFF_FFFD || illegal !== 1'b0 || branch_taken !== 1'b0) begin
      bad++;
      $display("FAIL mul_result: latency=%0d res=%h ill=%b br=%b, want 33/fffffffd/0/0",
               lat, result, illegal, branch_taken);
    end
    total++;
    if (ready_err || hold_err) begin
      bad++;
      $display("FAIL mul_busy: ready_err=%b hold_err=%b, want 0/0", ready_err, hold_err);
    end
    for (int i = 1; i <= 5 && wait2 == 0; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) wait2 = i;
    end
    in_valid = 1'b0;
    total++;
    if (wait2 != 2 || result !== 32'd123) begin
      bad++;
      $display("FAIL mul_held_op: cycles=%0d res=%h, want 2/0000007b", wait2, result);
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL mul_held_once: ov=%b, want 0", out_valid);
    end
  endtask
`endif

  task automatic test_async_reset();
    logic saw_valid;
    saw_valid = 1'b0;
    @(negedge clk);
    drive_op(6'd27, 32'd0, 32'd0, 32'h80, 32'h1000);
    @(negedge clk);
    in_valid = 1'b0;
`ifdef ALU_MUL_EN
    drive_op(6'd10, 32'd1234, 32'd5678, 32'd0, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
`endif
    // Assert reset mid-cycle: outputs must clear without a clock edge.
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || result !== 32'd0 || target !== 32'd0 ||
        branch_taken !== 1'b0 || illegal !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL async_reset: ov=%b res=%h tgt=%h br=%b ill=%b rdy=%b, want 0/0/0/0/0/1",
               out_valid, result, target, branch_taken, illegal, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (out_valid === 1'b1) saw_valid = 1'b1;
    end
    total++;
    if (saw_valid) begin
      bad++;
      $display("FAIL reset_abandon: ov seen=%b, want 0", saw_valid);
    end
    drive_op(6'd0, 32'd20, 32'd22, 32'd0, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || result !== 32'd42) begin
      bad++;
      $display("FAIL add_after_reset: ov=%b res=%h, want 1/0000002a", out_valid, result);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_back_to_back();
    test_directed();
    test_illegal();
    test_random();
`ifdef ALU_MUL_EN
    test_mul();
`endif
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
